// File: rtl/psg_pkg.sv
// Shared constants, types and helpers for the SN76489-style tone bank.
// PSG_ATTN_LOG_EN selects the 8-bit logarithmic volume table instead of linear 4-bit volume.
package psg_pkg;

  localparam int LATCH_BIT = 7;
  localparam int CH_LSB    = 5;
  localparam int TYPE_BIT  = 4;

  localparam int              ATTN_W   = 4;
  localparam logic [ATTN_W-1:0] ATTN_OFF = 4'hF;

`ifdef PSG_ATTN_LOG_EN
  localparam bit ATTN_LOG_EN = 1'b1;
`else
  localparam bit ATTN_LOG_EN = 1'b0;
`endif

  typedef enum logic {
    REG_PERIOD = 1'b0,
    REG_ATTN   = 1'b1
  } reg_type_e;

  // 2 dB per attenuation step; attenuation 15 is silence.
  localparam logic [7:0] LOG_TBL [16] = '{
    8'd255, 8'd203, 8'd161, 8'd128, 8'd102, 8'd81, 8'd64, 8'd51,
    8'd40,  8'd32,  8'd25,  8'd20,  8'd16,  8'd13, 8'd10, 8'd0
  };

  function automatic int vol_w(input bit log_en);
    return log_en ? 8 : 4;
  endfunction

  function automatic int mix_w(input int num_ch, input bit log_en);
    return vol_w(log_en) + $clog2(num_ch);
  endfunction

endpackage

// File: rtl/psg_tone_bank_if.sv
// Register-write bus of the tone bank: a single-cycle strobe with an SN76489-format byte.
interface psg_tone_bank_if;
  logic       wr_en;
  logic [7:0] wr_data;

  modport master (output wr_en, output wr_data);
  modport slave  (input  wr_en, input  wr_data);
endinterface

// File: rtl/psg_tone_channel.sv
// One square-wave tone channel: period/attenuation registers, half-period counter and volume.
// PSG_ATTN_LOG_EN switches the volume output to the logarithmic table.
module psg_tone_channel
  import psg_pkg::*;
#(
  parameter int PERIOD_W = 10,
  parameter int VOL_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              period_lo_we,
  input  logic              period_hi_we,
  input  logic              attn_we,
  input  logic [7:0]        data,
  output logic              sq,
  output logic [ATTN_W-1:0] attn,
  output logic [VOL_W-1:0]  vol
);

  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] period_nxt;
  logic [PERIOD_W-1:0] cnt;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    period_nxt = period;
    if (period_lo_we) period_nxt[3:0] = data[3:0];
    // Data bytes carry the upper period bits; the cast drops byte bits that do not fit.
    if (period_hi_we) period_nxt = PERIOD_W'({data, period[3:0]});
  end

  // NOTE: non-blocking assignments mean a tick on the same edge as a period
  // write still reloads from the old period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period <= '0;
      attn   <= ATTN_OFF;
      cnt    <= '0;
      sq     <= 1'b0;
    end else begin
      period <= period_nxt;
      if (attn_we) attn <= data[ATTN_W-1:0];
      if (tick) begin
        if (period <= PERIOD_W'(1)) begin
          sq  <= 1'b1;
          cnt <= period;
        end else if (cnt <= PERIOD_W'(1)) begin
          cnt <= period;
          sq  <= ~sq;
        end else begin
          cnt <= cnt - PERIOD_W'(1);
        end
      end
    end
  end

  always_comb begin
    vol = '0;
    if (sq) begin
`ifdef PSG_ATTN_LOG_EN
      vol = VOL_W'(LOG_TBL[attn]);
`else
      vol = VOL_W'(ATTN_OFF - attn);
`endif
    end
  end

endmodule

// File: rtl/psg_tone_bank.sv
// SN76489 tone bank: byte-protocol decoder, tick prescaler, NUM_CHANNELS tone channels, mixer.
// Define PSG_ATTN_LOG_EN for 8-bit logarithmic volume; default is linear 4-bit volume.
module psg_tone_bank
  import psg_pkg::*;
#(
  parameter  int NUM_CHANNELS = 3,
  parameter  int PERIOD_W     = 10,
  parameter  int CLK_DIV      = 16,
  localparam int VOL_W        = vol_w(ATTN_LOG_EN),
  localparam int MIX_W        = mix_w(NUM_CHANNELS, ATTN_LOG_EN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  psg_tone_bank_if.slave            bus,
  output logic [NUM_CHANNELS-1:0]   ch_out,
  output logic [4*NUM_CHANNELS-1:0] ch_attn,
  output logic [MIX_W-1:0]          mix_out,
  output logic                      tick
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PRE_W-1:0] presc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else if (presc == PRE_W'(CLK_DIV - 1)) begin
      presc <= '0;
      tick  <= 1'b1;
    end else begin
      presc <= presc + PRE_W'(1);
      tick  <= 1'b0;
    end
  end

  logic      is_latch;
  logic [1:0] sel_ch;
  reg_type_e sel_type;
  logic [1:0] latch_ch;
  reg_type_e latch_type;

  // Latch bytes address the register directly; data bytes reuse the last latch.
  assign is_latch = bus.wr_data[LATCH_BIT];
  assign sel_ch   = is_latch ? bus.wr_data[CH_LSB +: 2] : latch_ch;
  assign sel_type = is_latch ? reg_type_e'(bus.wr_data[TYPE_BIT]) : latch_type;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      latch_ch   <= 2'd0;
      latch_type <= REG_PERIOD;
    end else if (bus.wr_en && is_latch) begin
      latch_ch   <= sel_ch;
      latch_type <= sel_type;
    end
  end

  logic [VOL_W-1:0] vol [NUM_CHANNELS];

  // Channel numbers with no instance match no hit, so those writes vanish here.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic hit;
    assign hit = bus.wr_en && (sel_ch == 2'(i));

    psg_tone_channel #(
      .PERIOD_W (PERIOD_W),
      .VOL_W    (VOL_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick         (tick),
      .period_lo_we (hit && is_latch && (sel_type == REG_PERIOD)),
      .period_hi_we (hit && !is_latch && (sel_type == REG_PERIOD)),
      .attn_we      (hit && (sel_type == REG_ATTN)),
      .data         (bus.wr_data),
      .sq           (ch_out[i]),
      .attn         (ch_attn[4*i +: 4]),
      .vol          (vol[i])
    );
  end

  logic [MIX_W-1:0] mix_sum;

  // NOTE: blocking assignments are deliberate in combinational logic; the loop
  // accumulates within a single evaluation.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) mix_sum = mix_sum + MIX_W'(vol[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) mix_out <= '0;
    else        mix_out <= mix_sum;
  end

endmodule

// File: doc/psg_tone_bank.md
Name: psg_tone_bank

Overview:
- Parametrised tone-generator bank for the SN76489-family PSG.
- Holds NUM_CHANNELS square-wave channels with configurable period width.
- Decodes the SN76489 latch/data byte write protocol.
- Produces per-channel square bits plus a registered mixed amplitude.
- Sits between the top-level bus-input decode and the output DAC/PWM stage; replaces the fixed 3-channel, 10-bit tone logic.

Parameters:
- NUM_CHANNELS, 3, tone channels; legal range 1..4.
- PERIOD_W, 10, period register width; legal range 4..10.
- CLK_DIV, 16, master clocks per tone tick; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- wr_en  in  1  single-cycle write strobe.
- wr_data  in  8  SN76489-format register byte.
- ch_out  out  NUM_CHANNELS  per-channel square-wave level.
- ch_attn  out  4*NUM_CHANNELS  packed attenuation; channel i at [4i+3:4i].
- mix_out  out  MIX_W  registered sum of channel volumes.
  - MIX_W = VOL_W + $clog2(NUM_CHANNELS), with $clog2(1) = 0.
- tick  out  1  prescaler strobe, for bench and debug.

Behaviour:
- Reset (rst_n = 0 at a clk edge) sets:
  - all periods = 0, all attn = 4'hF, all counters = 0.
  - ch_out = 0, mix_out = 0, tick = 0, prescaler = 0.
  - latch = {channel 0, period}.
- Reset mid-operation discards all state on that edge. No write is accepted on a reset cycle.
- Write decode happens when wr_en = 1.
- Latch byte (wr_data[7] = 1):
  - latch channel = wr_data[6:5]; latch type = wr_data[4] (0 = period, 1 = attenuation).
  - Period type: period[3:0] = wr_data[3:0].
  - Attenuation type: attn = wr_data[3:0].
- Data byte (wr_data[7] = 0):
  - Latched type is period: period[PERIOD_W-1:4] = wr_data[PERIOD_W-5:0]. Bits above that are ignored.
  - Latched type is attenuation: attn = wr_data[3:0].
- Channel index >= NUM_CHANNELS: the register write is dropped, but the latch still updates.
- A register write becomes visible on the next clk edge.
- Prescaler:
  - Counts 0..CLK_DIV-1.
  - tick = 1 for one cycle when the count wraps to 0, i.e. every CLK_DIV cycles. The first tick comes CLK_DIV cycles after reset release.
- Per-channel behaviour on tick:
  - If period <= 1: ch_out is forced to 1 and the counter is loaded with period.
  - Else if counter <= 1: counter reloads with period and ch_out toggles.
  - Else: counter decrements.
  - Result: half-period = period ticks, so full period = 2*period*CLK_DIV clocks.
- A period write does not reset the counter; the new value is used at the next reload.
- A write and a tick in the same cycle: the tick uses the old period; the register takes the new value.
- Volume:
  - vol_i = ch_out[i] ? (15 - attn_i) : 0.
  - VOL_W = 4.
  - mix_out = sum of vol_i, registered; 1-cycle latency from ch_out/attn change.
- Arithmetic is unsigned with no overflow, guaranteed by MIX_W.

Optional Feature:
- Macro: PSG_ATTN_LOG_EN.
- Defined:
  - VOL_W = 8.
  - vol_i = ch_out[i] ? LOG_TBL[attn_i] : 0, giving 2 dB steps.
  - LOG_TBL = 255,203,161,128,102,81,64,51,40,32,25,20,16,13,10,0.
  - MIX_W = 8 + $clog2(NUM_CHANNELS).
- Undefined: linear 4-bit volume as above.

Decomposition:
- Package psg_pkg holds:
  - write-byte field positions (LATCH_BIT = 7, CH_LSB = 5, TYPE_BIT = 4).
  - ATTN_W = 4, ATTN_OFF = 4'hF.
  - reg-type enum {REG_PERIOD, REG_ATTN}.
  - LOG_TBL constant.
  - vol_w/mix_w helper functions.
- Sub-module psg_tone_channel, instantiated NUM_CHANNELS times via generate. It holds:
  - period register and attn register.
  - counter and square flop.
  - write-enable inputs, driven by the bank's decoder.

Test Plan:
- Reset with default parameters: ch_out = 0, mix_out = 0, ch_attn = 12'hFFF. tick first pulses exactly 16 cycles after rst_n rises.
- Write 0x8E, 0x0F, 0x90 (channel 0 period = 0x0FE, attn = 0):
  - ch_out[0] toggles every 254 ticks (4064 clocks).
  - mix_out alternates 15/0 (linear) or 255/0 (PSG_ATTN_LOG_EN).
- Write 0xA1, 0xB3 (channel 1 period = 1, attn = 3): ch_out[1] is held at 1 and mix_out steady at 12 (linear).
- NUM_CHANNELS = 2, write 0xD0 then 0x05:
  - Channels 0 and 1 are unchanged.
  - A following 0x05 data byte is also dropped, since the latch points to channel 2.
- Channel 0 running with period 0x10:
  - Write a new period on the same cycle as a tick.
  - Current half-period completes at 16 ticks; the next half-period uses the new value.
- Assert rst_n = 0 for one cycle mid-tone: all outputs return to reset values on that edge, and the prescaler restarts.
